// File: rtl/imm_gen_pkg.sv
// Shared definitions for the pipelined immediate generator.
// Holds RV32I/RV64I opcode constants, the immediate-format enum and the
// decoded-entry struct stored in the output elastic buffer.
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Widest supported datapath; entries always store this many immediate bits.
    localparam int unsigned IMM_MAX_W = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } imm_fmt_e;

    // The sideband tag is parameterised per instance, so it is stored in a
    // parallel array next to these entries rather than inside the struct.
    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_e             fmt;
        logic                 illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Pure combinational RV32I/RV64I immediate decoder.
// Ports:
//   i_inst    - 32-bit instruction word
//   o_imm     - sign-extended immediate, XLEN bits (0 for R-type / illegal)
//   o_fmt     - immediate format classification
//   o_illegal - opcode unsupported for this XLEN
module imm_decode_comb
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     i_inst,
    output logic [XLEN-1:0] o_imm,
    output imm_fmt_e        o_fmt,
    output logic            o_illegal
);

    logic [6:0]         w_opc;
    logic signed [11:0] w_imm_i;
    logic signed [11:0] w_imm_s;
    logic signed [12:0] w_imm_b;
    logic signed [31:0] w_imm_u;
    logic signed [20:0] w_imm_j;

    assign w_opc   = i_inst[6:0];
    assign w_imm_i = $signed(i_inst[31:20]);
    assign w_imm_s = $signed({i_inst[31:25], i_inst[11:7]});
    assign w_imm_b = $signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0});
    assign w_imm_u = $signed({i_inst[31:12], 12'b0});
    assign w_imm_j = $signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0});

    // Size casts of signed operands sign-extend to XLEN.
    always_comb begin
        o_imm     = '0;
        o_fmt     = FMT_NONE;
        o_illegal = 1'b0;
        case (w_opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_FENCE, OPC_SYSTEM: begin
                o_fmt = FMT_I;
                o_imm = XLEN'(w_imm_i);
            end
            OPC_OP_IMM32: begin
                if (XLEN == 64) begin
                    o_fmt = FMT_I;
                    o_imm = XLEN'(w_imm_i);
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                o_fmt = FMT_S;
                o_imm = XLEN'(w_imm_s);
            end
            OPC_BRANCH: begin
                o_fmt = FMT_B;
                o_imm = XLEN'(w_imm_b);
            end
            OPC_LUI, OPC_AUIPC: begin
                o_fmt = FMT_U;
                o_imm = XLEN'(w_imm_u);
            end
            OPC_JAL: begin
                o_fmt = FMT_J;
                o_imm = XLEN'(w_imm_j);
            end
            OPC_OP: begin
                o_fmt = FMT_R;
            end
            OPC_OP32: begin
                if (XLEN == 64) begin
                    o_fmt = FMT_R;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes each accepted instruction and
// holds the result in a 2-entry elastic buffer with valid/ready on both
// sides. No combinational path from inputs to outputs.
// Ports:
//   clk, reset       - clock; asynchronous active-high reset
//   flush            - synchronous buffer flush (drops any offered instruction)
//   in_valid/in_ready, in_inst, in_tag  - upstream handshake and payload
//   out_valid/out_ready                 - downstream handshake
//   out_imm, out_fmt, out_illegal, out_tag - head entry (zero when empty)
//   illegal_cnt      - saturating count of accepted illegal instructions
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output imm_fmt_e         out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [XLEN-1:0]  w_dec_imm;
    imm_fmt_e         w_dec_fmt;
    logic             w_dec_illegal;
    imm_entry_t       w_entry;

    imm_entry_t       r_mem [2];
    logic [TAG_W-1:0] r_tag [2];
    logic             r_wptr, w_wptr_d;
    logic             r_rptr, w_rptr_d;
    logic [1:0]       r_count, w_count_d;
    logic [CNT_W-1:0] r_ill_cnt, w_ill_cnt_d;
    logic             w_push, w_pop;
    imm_entry_t       w_head;

    imm_decode_comb #(
        .XLEN (XLEN)
    ) u_decode (
        .i_inst    (in_inst),
        .o_imm     (w_dec_imm),
        .o_fmt     (w_dec_fmt),
        .o_illegal (w_dec_illegal)
    );

    always_comb begin
        w_entry                = '0;
        w_entry.imm[XLEN-1:0]  = w_dec_imm;
        w_entry.fmt            = w_dec_fmt;
        w_entry.illegal        = w_dec_illegal;
    end

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);

    // Flush overrides any handshake in the same cycle.
    assign w_push = in_valid && in_ready && !flush;
    assign w_pop  = out_valid && out_ready && !flush;

    always_comb begin
        w_count_d   = r_count;
        w_wptr_d    = r_wptr;
        w_rptr_d    = r_rptr;
        w_ill_cnt_d = r_ill_cnt;
        if (flush) begin
            w_count_d = 2'd0;
            w_wptr_d  = 1'b0;
            w_rptr_d  = 1'b0;
        end else begin
            if (w_push) begin
                w_wptr_d = ~r_wptr;
            end
            if (w_pop) begin
                w_rptr_d = ~r_rptr;
            end
            w_count_d = r_count + 2'(w_push) - 2'(w_pop);
            if (w_push && w_dec_illegal && (r_ill_cnt != '1)) begin
                w_ill_cnt_d = r_ill_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= 2'd0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_ill_cnt <= '0;
        end else begin
            r_count   <= w_count_d;
            r_wptr    <= w_wptr_d;
            r_rptr    <= w_rptr_d;
            r_ill_cnt <= w_ill_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
                r_tag[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= w_entry;
            r_tag[r_wptr] <= in_tag;
        end
    end

    // Outputs read as zero while empty so stale entries never leak out.
    assign w_head      = r_mem[r_rptr];
    assign out_imm     = out_valid ? w_head.imm[XLEN-1:0] : '0;
    assign out_fmt     = out_valid ? w_head.fmt : FMT_NONE;
    assign out_illegal = out_valid ? w_head.illegal : 1'b0;
    assign out_tag     = out_valid ? r_tag[r_rptr] : '0;
    assign illegal_cnt = r_ill_cnt;

endmodule
